// File: rtl/sync_scan_seq_if.sv
// Handshake and scan-chain signals between a host and the scan sequencer.
// The slave modport is the sequencer's view and the master modport is the host/chain side.
interface sync_scan_seq_if #(
  parameter int unsigned CHAIN_MAX = 8,
  parameter int unsigned DW        = 2 * CHAIN_MAX
);
  logic                               start;
  logic [$clog2(CHAIN_MAX + 1) - 1:0] cfg_len;
  logic [DW - 1:0]                    wr_data;
  logic                               so_in;
  logic                               ss;
  logic                               si;
  logic                               busy;
  logic                               done;
  logic                               err;
  logic [DW - 1:0]                    rd_data;

  modport master (
    output start, cfg_len, wr_data, so_in,
    input  ss, si, busy, done, err, rd_data
  );

  modport slave (
    input  start, cfg_len, wr_data, so_in,
    output ss, si, busy, done, err, rd_data
  );
endinterface

// File: rtl/sync_scan_seq.sv
// Shift-and-capture sequencer for a chain of two-stage synchronizer cells.
// It shifts a pattern in LSB first, collects scan-out, and then pulses a single functional capture.
module sync_scan_seq #(
  parameter int unsigned CHAIN_MAX = 8,
  parameter int unsigned DW        = 2 * CHAIN_MAX
) (
  input logic            ck,
  input logic            rb,
  sync_scan_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(2 * CHAIN_MAX);

  typedef enum logic [1:0] {StIdle, StShift, StCapture, StDone} state_e;

  state_e          r_state;
  logic [DW-1:0]   r_tx;
  logic [DW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_idx;
  logic            r_ss;
  logic            r_si;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_len_ok;
  logic [CW-1:0]   w_cnt_init;
  logic [DW-1:0]   w_tx_next;

  assign w_len_ok   = (bus.cfg_len != '0) && (32'(bus.cfg_len) <= CHAIN_MAX);
  assign w_cnt_init = CW'((32'd2 * 32'(bus.cfg_len)) - 32'd1);
  assign w_tx_next  = r_tx >> 1;

  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      r_state <= StIdle;
      r_tx    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ss    <= 1'b0;
      r_si    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            if (w_len_ok) begin
              r_state <= StShift;
              r_tx    <= bus.wr_data;
              r_rd    <= '0;
              r_cnt   <= w_cnt_init;
              r_idx   <= '0;
              r_ss    <= 1'b1;
              r_si    <= bus.wr_data[0];
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StShift: begin
          // si is kept registered as the bit tx[0] will hold after this shift.
          r_tx  <= w_tx_next;
          r_cnt <= r_cnt - 1'b1;
          r_idx <= r_idx + 1'b1;
          if (32'(r_idx) < DW) begin
            r_rd[r_idx] <= bus.so_in;
          end
          if (r_cnt == '0) begin
            r_state <= StCapture;
            r_ss    <= 1'b0;
            r_si    <= 1'b0;
          end else begin
            r_si <= w_tx_next[0];
          end
        end
        StCapture: begin
          r_state <= StDone;
          r_done  <= 1'b1;
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.ss      = r_ss;
  assign bus.si      = r_si;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rd_data = r_rd;
endmodule

// File: doc/sync_scan_seq.md
SYNC_SCAN_SEQ -- requirements
Module: sync_scan_seq

Interface
REQ-001 Parameter CHAIN_MAX, default 8, SHALL set the maximum number of two-stage synchronizer cells on the controlled scan chain (2*CHAIN_MAX flops).
REQ-002 Parameter DW, default 2*CHAIN_MAX, SHALL set the width of the shift-in and shift-out data words.
REQ-003 ck  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rb  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 start  in  1  SHALL be a one-cycle pulse requesting a shift-and-capture operation.
REQ-006 cfg_len  in  $clog2(CHAIN_MAX+1)  SHALL give the active chain length in cells, sampled on an accepted start.
REQ-007 wr_data  in  DW  SHALL be the pattern to shift in, LSB first, sampled on an accepted start.
REQ-008 so_in  in  1  SHALL carry the chain's last-cell scan-out; it is forced high by the cells whenever ss=0.
REQ-009 ss  out  1  SHALL drive scan-select to every cell on the chain.
REQ-010 si  out  1  SHALL drive scan-in of the first cell.
REQ-011 busy  out  1  SHALL be high in every state except IDLE.
REQ-012 done  out  1  SHALL pulse high for one cycle when an operation completes.
REQ-013 err  out  1  SHALL pulse high for one cycle when a start is rejected.
REQ-014 rd_data  out  DW  SHALL hold the bits shifted out of the chain, valid from the done pulse until the next accepted start.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT, CAPTURE and DONE.
REQ-016 In IDLE, start=1 with 1<=cfg_len<=CHAIN_MAX SHALL load wr_data into the tx register, clear rd_data, set bit counter cnt=2*cfg_len-1, and enter SHIFT.
REQ-017 In IDLE, start=1 with cfg_len=0 or cfg_len>CHAIN_MAX SHALL pulse err for one cycle and stay in IDLE; no other output changes.
REQ-018 A start received while busy=1 SHALL be ignored: no err pulse and no state change.
REQ-019 In SHIFT, ss SHALL be 1 and si SHALL equal tx[0] (registered output; no combinational path from start to si).
REQ-020 Each SHIFT cycle SHALL: shift tx right by one; sample so_in into rd_data[k], where k=0 for the first SHIFT cycle and increments by one per cycle; and decrement cnt.
REQ-021 SHIFT SHALL last exactly 2*cfg_len cycles; the cycle with cnt=0 SHALL transition to CAPTURE.
REQ-022 Bits of rd_data at index 2*cfg_len and above SHALL read 0.
REQ-023 In CAPTURE, ss SHALL be 0 and si SHALL be 0 for exactly one cycle, so that the cells take one functional d sample; the FSM then enters DONE.
REQ-024 In DONE, ss SHALL be 0, done SHALL be 1 for one cycle, and the FSM returns to IDLE.
REQ-025 Start-to-done latency SHALL be 2*cfg_len+2 cycles, counted from the start edge to the cycle in which done is high.
REQ-026 Outside SHIFT, ss SHALL be 0 and si SHALL be 0.
REQ-027 A start sampled in the same cycle that done is high SHALL be ignored, because the FSM is not in IDLE in that cycle.

Reset
REQ-028 rb=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, ss=0, si=0, busy=0, done=0, err=0, rd_data=0, tx=0, cnt=0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after deassertion the block SHALL accept a new start on the first rising edge.
REQ-030 No output SHALL glitch high during reset deassertion.

Verification
REQ-031 cfg_len=1, wr_data=0b10, so_in model preloaded with 0b11 -> ss high for 2 cycles, si sequence 0 then 1, done at cycle 4 after start, rd_data=0x0003.
REQ-032 cfg_len=8, wr_data=0xA5C3 looped back through a 16-flop chain model, then a second operation with wr_data=0 -> second rd_data=0xA5C3.
REQ-033 start with cfg_len=0, then start with cfg_len=9 -> err pulses once for each start, busy stays 0, ss stays 0.
REQ-034 start pulsed during SHIFT and again in the DONE cycle -> both ignored, exactly one done, err never asserted.
REQ-035 rb asserted low at the 3rd SHIFT cycle of a cfg_len=4 operation -> ss and busy fall asynchronously, no done; a new start after release completes normally with latency 10.
REQ-036 so_in observed with ss=0 (CAPTURE, DONE, IDLE) -> reads 1 and never corrupts rd_data.
